// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for fp_div. Defining FPDIV_STATUS_EN adds the
// flags field; it must be defined consistently for the interface and the divider.
interface fp_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] I1;
  logic [31:0] I2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
`ifdef FPDIV_STATUS_EN
  logic [3:0]  flags;

  modport master (output in_valid, I1, I2, out_ready,
                  input  in_ready, out_valid, out, flags);
  modport slave  (input  in_valid, I1, I2, out_ready,
                  output in_ready, out_valid, out, flags);
`else
  modport master (output in_valid, I1, I2, out_ready,
                  input  in_ready, out_valid, out);
  modport slave  (input  in_valid, I1, I2, out_ready,
                  output in_ready, out_valid, out);
`endif
endinterface

// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider (I1 / I2), restoring mantissa division,
// truncating, denormals flushed. Optional macro FPDIV_STATUS_EN adds the status flags.
module fp_div #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter logic [31:0] NAN_VAL        = 32'hFFFF_FFFF
) (
  input  logic    clk,
  input  logic    rst_n,
  fp_div_if.slave bus
);
  localparam int unsigned QW    = 25;
  localparam int unsigned RW    = 26;
  localparam int unsigned NW    = 24;
  localparam int unsigned EW    = 10;
  localparam int unsigned STEPS = QW / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t               state;
  logic [RW-1:0]        rem;
  logic [NW-1:0]        div_n;
  logic [QW-1:0]        quo;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic signed [EW-1:0] exp_q;

  // Operand fields and classification of the offered operands
  logic [7:0]  e1_c, e2_c;
  logic [22:0] m1_c, m2_c;
  logic        a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c, sign_c;

  assign e1_c     = bus.I1[30:23];
  assign e2_c     = bus.I2[30:23];
  assign m1_c     = bus.I1[22:0];
  assign m2_c     = bus.I2[22:0];
  assign sign_c   = bus.I1[31] ^ bus.I2[31];
  assign a_zero_c = (e1_c == 8'd0);
  assign b_zero_c = (e2_c == 8'd0);
  assign a_inf_c  = (e1_c == 8'hFF) && (m1_c == 23'd0);
  assign b_inf_c  = (e2_c == 8'hFF) && (m2_c == 23'd0);
  assign a_nan_c  = (e1_c == 8'hFF) && (m1_c != 23'd0);
  assign b_nan_c  = (e2_c == 8'hFF) && (m2_c != 23'd0);

  // Special-case result, highest priority first
  logic        special_c, invalid_c, dbz_c;
  logic [31:0] spec_out_c;

  always_comb begin
    special_c  = 1'b1;
    invalid_c  = 1'b0;
    dbz_c      = 1'b0;
    spec_out_c = NAN_VAL;
    if (a_nan_c || b_nan_c || (a_inf_c && b_inf_c) || (a_zero_c && b_zero_c)) begin
      invalid_c = 1'b1;
    end else if (a_inf_c) begin
      spec_out_c = {sign_c, 8'hFF, 23'd0};
    end else if (b_zero_c) begin
      spec_out_c = {sign_c, 8'hFF, 23'd0};
      dbz_c      = 1'b1;
    end else if (b_inf_c || a_zero_c) begin
      spec_out_c = {sign_c, 31'd0};
    end else begin
      special_c = 1'b0;
    end
  end

  // BITS_PER_CYCLE restoring steps per DIVIDE cycle
  logic [RW-1:0]             rem_nxt_c;
  logic [BITS_PER_CYCLE-1:0] qbits_c;

  always_comb begin
    rem_nxt_c = rem;
    qbits_c   = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (rem_nxt_c >= RW'(div_n)) begin
        qbits_c[BITS_PER_CYCLE-1-i] = 1'b1;
        rem_nxt_c                   = rem_nxt_c - RW'(div_n);
      end
      rem_nxt_c = rem_nxt_c << 1;
    end
  end

  // Normalisation of the quotient and exponent range handling
  logic signed [EW-1:0] exp_n_c;
  logic [22:0]          man_c;
  logic                 ovf_c, unf_c;
  logic [31:0]          norm_out_c;

  always_comb begin
    if (quo[QW-1]) begin
      man_c   = quo[23:1];
      exp_n_c = exp_q;
    end else begin
      man_c   = quo[22:0];
      exp_n_c = exp_q - 10'sd1;
    end
    ovf_c = (exp_n_c >= 10'sd255);
    unf_c = (exp_n_c <= 10'sd0);
    if (ovf_c)      norm_out_c = {sign, 8'hFF, 23'd0};
    else if (unf_c) norm_out_c = {sign, 31'd0};
    else            norm_out_c = {sign, exp_n_c[7:0], man_c};
  end

`ifdef FPDIV_STATUS_EN
  logic denorm_c;
  assign denorm_c = (a_zero_c && (m1_c != 23'd0)) || (b_zero_c && (m2_c != 23'd0));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out       <= 32'h0;
      rem           <= '0;
      div_n         <= '0;
      quo           <= '0;
      cnt           <= '0;
      sign          <= 1'b0;
      exp_q         <= '0;
`ifdef FPDIV_STATUS_EN
      bus.flags     <= 4'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign         <= sign_c;
            rem          <= RW'({|e1_c, m1_c});
            div_n        <= {|e2_c, m2_c};
            exp_q        <= $signed({2'b00, e1_c}) - $signed({2'b00, e2_c}) + 10'sd127;
            quo          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
`ifdef FPDIV_STATUS_EN
            bus.flags    <= {invalid_c, dbz_c, 1'b0, denorm_c};
`endif
            if (special_c) begin
              bus.out       <= spec_out_c;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_nxt_c;
          quo <= QW'({quo, qbits_c});
          if (cnt == CW'(STEPS - 1)) begin
            cnt   <= '0;
            state <= NORM;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        NORM: begin
          bus.out       <= norm_out_c;
          bus.out_valid <= 1'b1;
`ifdef FPDIV_STATUS_EN
          bus.flags[1]  <= ovf_c;
          bus.flags[0]  <= bus.flags[0] | unf_c;
`endif
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div.sv
// Randomised and directed bench for fp_div against an arithmetic reference model.
module tb_fp_div;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_div_if bus ();

  fp_div #(.BITS_PER_CYCLE(1), .NAN_VAL(32'hFFFF_FFFF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient floor(N1*2^24/N2), then IEEE packing rules
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f,
                                output bit sp);
    int          ea = int'(a[30:23]);
    int          eb = int'(b[30:23]);
    logic        s  = a[31] ^ b[31];
    bit          nan_a  = (ea == 255) && (a[22:0] != 0);
    bit          nan_b  = (eb == 255) && (b[22:0] != 0);
    bit          inf_a  = (ea == 255) && (a[22:0] == 0);
    bit          inf_b  = (eb == 255) && (b[22:0] == 0);
    bit          zero_a = (ea == 0);
    bit          zero_b = (eb == 0);
    longint      na, nb, q, m;
    int          e;
    f    = 4'h0;
    f[0] = (zero_a && a[22:0] != 0) || (zero_b && b[22:0] != 0);
    sp   = 1'b1;
    if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) begin
      r = 32'hFFFF_FFFF; f[3] = 1'b1;
    end else if (inf_a) begin
      r = {s, 8'hFF, 23'd0};
    end else if (zero_b) begin
      r = {s, 8'hFF, 23'd0}; f[2] = 1'b1;
    end else if (inf_b || zero_a) begin
      r = {s, 31'd0};
    end else begin
      sp = 1'b0;
      na = 64'h80_0000 | longint'(a[22:0]);
      nb = 64'h80_0000 | longint'(b[22:0]);
      q  = (na << 24) / nb;
      e  = ea - eb + 127;
      if (q >= (64'd1 << 24)) m = (q >> 1) & 64'h7F_FFFF;
      else begin m = q & 64'h7F_FFFF; e = e - 1; end
      if (e >= 255)    begin r = {s, 8'hFF, 23'd0}; f[1] = 1'b1; end
      else if (e <= 0) begin r = {s, 31'd0};        f[0] = 1'b1; end
      else r = {s, 8'(e), 23'(m)};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m = 23'($urandom);
    case ($urandom_range(0, 9))
      0: begin e = 8'd0; m = 23'd0; end
      1: begin e = 8'd0; m = m | 23'd1; end
      2: begin e = 8'hFF; m = 23'd0; end
      3: begin e = 8'hFF; m = m | 23'd1; end
      4: e = ($urandom_range(0, 1) == 1) ? 8'd1 : 8'd254;
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // One operation: offer, measure latency, check result, optional backpressure, handshake
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                        input string tag);
    logic [31:0] er;
    logic [3:0]  ef;
    bit          sp;
    int          lat = 0;
    model(a, b, er, ef, sp);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.I1        = a;
    bus.I2        = b;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = 1'b0;
        bus.I1       = $urandom;
        bus.I2       = $urandom;
        check({tag, ":in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      end
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, ":latency"}, 32'(lat), sp ? 32'd1 : 32'd27);
    check({tag, ":out"}, bus.out, er);
`ifdef FPDIV_STATUS_EN
    check({tag, ":flags"}, 32'(bus.flags), 32'(ef));
`endif
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ":hold_out"}, bus.out, er);
      check({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.I1        = 32'h0;
    bus.I2        = 32'h0;
    repeat (3) @(negedge clk);
    check("rst:in_ready", 32'(bus.in_ready), 32'd1);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:out", bus.out, 32'h0);
    rst_n = 1'b1;

    run_op(32'h40C0_0000, 32'h4000_0000, 0, "6div2");
    run_op(32'h3F80_0000, 32'h4040_0000, 0, "1div3");
    run_op(32'hC0C0_0000, 32'h4000_0000, 5, "neg6div2_bp");
    run_op(32'h3F80_0000, 32'h4000_0000, 0, "b2b_1div2");
    run_op(32'h3F80_0000, 32'h0000_0000, 0, "1div0");
    run_op(32'hBF80_0000, 32'h0000_0000, 0, "m1div0");
    run_op(32'h0000_0000, 32'h0000_0000, 0, "0div0");
    run_op(32'h7F00_0000, 32'h0080_0000, 0, "ovf");
    run_op(32'h0080_0000, 32'h7F00_0000, 0, "unf");
    run_op(32'h7F80_0000, 32'h7F80_0000, 0, "infdivinf");
    check("idle_keeps_out", bus.out, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of DIVIDE
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.I1        = 32'h40C0_0000;
    bus.I2        = 32'h4000_0000;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst:out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst:in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    bus.out_ready = 1'b0;
    check("midrst:no_stale", 32'(seen_valid), 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 0, "post_rst_6div2");

    for (int i = 0; i < 40; i++) begin
      run_op(rand_fp(), rand_fp(), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
